// File: rtl/send_sched_pkg.sv
// Shared constants for the send scheduler: FSM state encodings and
// frame-ordering mode selectors.
package send_sched_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_GAP       = 3'd2;
  localparam logic [2:0] ST_REQ       = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_ADVANCE   = 3'd5;

  // Frame ordering within a round
  localparam logic MODE_COPY_MAJOR = 1'b0;  // all segments of txid 1, then txid 2 ...
  localparam logic MODE_SEG_MAJOR  = 1'b1;  // seg 0 txid 1..R, then seg 1 ...

endpackage

// File: rtl/send_gap_timer.sv
// Idle-gap timer: counts consecutive non-busy cycles while running and
// reports when the count reaches the target on a non-busy cycle. Any busy
// cycle restarts the count, so the gap is always measured as an unbroken
// quiet stretch on the frame generator.
import send_sched_pkg::*;

module send_gap_timer #(
  parameter int GAP_W = 28
) (
  input  logic             clk125MHz,
  input  logic             RST,
  input  logic             i_run,
  input  logic             i_busy,
  input  logic [GAP_W-1:0] i_target,
  output logic             o_done
);

  logic [GAP_W-1:0] r_count;

  // Target reached on a quiet cycle; a target of 0 fires on the first quiet cycle.
  assign o_done = i_run && !i_busy && (r_count == i_target);

  // Count quiet cycles; clear when stopped, on busy, or once the gap is satisfied.
  always_ff @(posedge clk125MHz) begin
    if (RST || !i_run || i_busy || o_done) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + GAP_W'(1);
    end
  end

endmodule

// File: rtl/send_scheduler.sv
// Transmit scheduler: walks segment number and copy id through one round
// of frames using config latched at the start of each round, spaces
// requests by a programmable quiet gap and hands each frame to the frame
// generator with a req/busy handshake. Rounds always run to completion.
import send_sched_pkg::*;

module send_scheduler #(
  parameter int SEG_W  = 16,
  parameter int TXID_W = 8,
  parameter int AUX_W  = 8,
  parameter int GAP_W  = 28
) (
  input  logic              clk125MHz,
  input  logic              RST,
  input  logic              enable,
  input  logic [SEG_W-1:0]  cfg_seg_count,
  input  logic [TXID_W-1:0] cfg_redundancy,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              cfg_mode,
  input  logic              busy,
  output logic              send_req,
  output logic [SEG_W-1:0]  seg_num,
  output logic [TXID_W-1:0] txid,
  output logic [AUX_W-1:0]  aux,
  output logic              first_copy,
  output logic              round_done,
  output logic              active
);

  logic [2:0]        r_state;
  logic [SEG_W-1:0]  r_seg;
  logic [TXID_W-1:0] r_txid;
  logic [AUX_W-1:0]  r_aux;
  logic [SEG_W-1:0]  r_seg_count_l;
  logic [TXID_W-1:0] r_red_l;
  logic [GAP_W-1:0]  r_gap_l;
  logic              r_mode_l;

  logic w_gap_done;
  logic w_seg_wrap;
  logic w_txid_wrap;
  logic w_last;

  send_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk125MHz (clk125MHz),
    .RST       (RST),
    .i_run     (r_state == ST_GAP),
    .i_busy    (busy),
    .i_target  (r_gap_l),
    .o_done    (w_gap_done)
  );

  // Full-width comparisons against the latched round configuration.
  assign w_seg_wrap  = (r_seg == r_seg_count_l - SEG_W'(1));
  assign w_txid_wrap = (r_txid == r_red_l);
  assign w_last      = w_seg_wrap && w_txid_wrap;

  assign send_req   = (r_state == ST_REQ);
  assign seg_num    = r_seg;
  assign txid       = r_txid;
  assign aux        = r_aux;
  assign first_copy = (r_txid == TXID_W'(1));
  assign round_done = (r_state == ST_ADVANCE) && w_last;
  assign active     = (r_state != ST_IDLE);

  // Round sequencing FSM with index stepping and per-round config latch.
  always_ff @(posedge clk125MHz) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_seg         <= '0;
      r_txid        <= TXID_W'(1);
      r_aux         <= '0;
      r_seg_count_l <= SEG_W'(1);
      r_red_l       <= TXID_W'(1);
      r_gap_l       <= '0;
      r_mode_l      <= MODE_COPY_MAJOR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_seg_count_l <= (cfg_seg_count == '0) ? SEG_W'(1) : cfg_seg_count;
          r_red_l       <= (cfg_redundancy == '0) ? TXID_W'(1) : cfg_redundancy;
          r_gap_l       <= cfg_gap;
          r_mode_l      <= cfg_mode;
          r_seg         <= '0;
          r_txid        <= TXID_W'(1);
          r_state       <= ST_GAP;
        end
        ST_GAP: begin
          if (w_gap_done) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (busy) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!busy) r_state <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          if (w_last) begin
            // Indices stay on the final frame so outputs show the last request.
            r_aux   <= r_aux + AUX_W'(1);
            r_state <= enable ? ST_LOAD : ST_IDLE;
          end else begin
            if (r_mode_l == MODE_COPY_MAJOR) begin
              if (w_seg_wrap) begin
                r_seg  <= '0;
                r_txid <= r_txid + TXID_W'(1);
              end else begin
                r_seg <= r_seg + SEG_W'(1);
              end
            end else begin
              if (w_txid_wrap) begin
                r_txid <= TXID_W'(1);
                r_seg  <= r_seg + SEG_W'(1);
              end else begin
                r_txid <= r_txid + TXID_W'(1);
              end
            end
            r_state <= ST_GAP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
